// File: rtl/spw_pkg.sv
// Shared SpaceWire transmit constants: control codes, character lengths,
// the N-char layout and the character transmitter state encoding.
package spw_pkg;

  localparam logic [1:0] CTRL_FCT = 2'b00;
  localparam logic [1:0] CTRL_EOP = 2'b01;
  localparam logic [1:0] CTRL_EEP = 2'b10;
  localparam logic [1:0] CTRL_ESC = 2'b11;

  localparam logic [3:0] CTRL_LEN = 4'd4;
  localparam logic [3:0] DATA_LEN = 4'd10;

  typedef struct packed {
    logic       ctrl;
    logic [7:0] bits;
  } nchar_t;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_SEND,
    ST_ESC2
  } tx_state_e;

endpackage

// File: rtl/spw_ds_encoder.sv
// Data-strobe line encoder: D follows the bit, S toggles whenever D repeats,
// so D^S changes on every emitted bit. Cleared by reset or a disabled link.
module spw_ds_encoder (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid,
  input  logic tx_bit,
  output logic data,
  output logic strobe
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data   <= 1'b0;
      strobe <= 1'b0;
    end else if (!en) begin
      data   <= 1'b0;
      strobe <= 1'b0;
    end else if (valid) begin
      data   <= tx_bit;
      strobe <= (tx_bit == data) ? ~strobe : strobe;
    end
  end

endmodule

// File: rtl/spw_char_tx.sv
// SpaceWire character transmitter: time-code / FCT / N-char / NULL serialiser.
// Optional time-code port and top-priority time-code path: SPW_TIME_CODE_EN.
module spw_char_tx
  import spw_pkg::*;
(
  input  logic       tx_clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fct_req,
  output logic       fct_ack,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [8:0] char_data,
`ifdef SPW_TIME_CODE_EN
  input  logic       tc_valid,
  output logic       tc_ready,
  input  logic [7:0] tc_data,
`endif
  output logic       data,
  output logic       strobe
);

  tx_state_e  state;
  logic [9:0] shreg;
  logic [3:0] cnt;
  logic       hist;
  logic       first;
  logic       esc_tc;
  logic [7:0] tc_buf;

  logic       tc_v;
  logic [7:0] tc_d;
  logic       load, arb, win_tc, win_fct, win_chr;
  logic       esc_load, flag, par, tx_bit, shift_en;
  logic [7:0] payload;
  logic [3:0] len;
  nchar_t     nc;

`ifdef SPW_TIME_CODE_EN
  assign tc_v     = tc_valid;
  assign tc_d     = tc_data;
  assign tc_ready = win_tc;
`else
  assign tc_v = 1'b0;
  assign tc_d = '0;
`endif

  assign nc       = char_data;
  assign load     = en && (state != ST_OFF) && (cnt == '0);
  // Sources only compete outside the forced ESC second half and the initial NULL
  assign arb      = load && (state == ST_SEND) && !first;
  assign win_tc   = arb && tc_v;
  assign win_fct  = arb && !tc_v && fct_req;
  assign win_chr  = arb && !tc_v && !fct_req && char_valid;
  assign fct_ack    = win_fct;
  assign char_ready = win_chr;
  assign shift_en   = en && (state != ST_OFF);

  always_comb begin
    flag     = 1'b1;
    payload  = {6'b0, CTRL_ESC};
    len      = CTRL_LEN;
    esc_load = 1'b0;
    if (state == ST_ESC2) begin
      if (esc_tc) begin
        flag    = 1'b0;
        payload = tc_buf;
        len     = DATA_LEN;
      end else begin
        payload = {6'b0, CTRL_FCT};
      end
    end else if (win_fct) begin
      payload = {6'b0, CTRL_FCT};
    end else if (win_chr) begin
      if (nc.ctrl) begin
        payload = {6'b0, (nc.bits[1:0] == CTRL_EOP) ? CTRL_EOP : CTRL_EEP};
      end else begin
        flag    = 1'b0;
        payload = nc.bits;
        len     = DATA_LEN;
      end
    end else begin
      esc_load = 1'b1;
    end
    par    = ~(flag ^ hist);
    tx_bit = load ? par : shreg[0];
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state  <= ST_OFF;
      shreg  <= '0;
      cnt    <= '0;
      hist   <= 1'b0;
      first  <= 1'b0;
      esc_tc <= 1'b0;
      tc_buf <= '0;
    end else if (!en) begin
      state  <= ST_OFF;
      shreg  <= '0;
      cnt    <= '0;
      hist   <= 1'b0;
      first  <= 1'b0;
      esc_tc <= 1'b0;
    end else if (state == ST_OFF) begin
      state <= ST_SEND;
      first <= 1'b1;
      cnt   <= '0;
    end else if (cnt == '0) begin
      // P goes straight to the line; shreg keeps flag + payload for later cycles
      shreg <= {1'b0, payload, flag};
      cnt   <= len - 4'd1;
      hist  <= ^payload;
      first <= 1'b0;
      if (state == ST_ESC2) begin
        state <= ST_SEND;
      end else if (esc_load) begin
        state  <= ST_ESC2;
        esc_tc <= win_tc;
        if (win_tc) tc_buf <= tc_d;
      end
    end else begin
      shreg <= {1'b0, shreg[9:1]};
      cnt   <= cnt - 4'd1;
    end
  end

  spw_ds_encoder u_enc (
    .clk    (tx_clk),
    .rst    (rst),
    .en     (en),
    .valid  (shift_en),
    .tx_bit (tx_bit),
    .data   (data),
    .strobe (strobe)
  );

endmodule
